// File: rtl/psdsqrt_seq.sv
// psdsqrt_seq: valid/ready operand sequencer driving the psdsqrt core.
// Define PSDSQRT_SEQ_CHECK_EN to add the r*r <= x < (r+1)^2 result check.
module psdsqrt_seq #(
    parameter int NUM_BITS = 32,
    parameter int LATENCY  = NUM_BITS / 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_BITS/2-1:0] out_data,
    output logic                  sq_start,
    output logic                  sq_stop,
    output logic [NUM_BITS-1:0]   sq_xin,
    input  logic [NUM_BITS/2-1:0] sq_sqrt,
    output logic                  busy,
    output logic                  check_err
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int XW = NUM_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        STOP,
        CAPT,
        OUT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          chk_fail;

`ifdef PSDSQRT_SEQ_CHECK_EN
    logic [XW-1:0] r_ext;
    logic [XW-1:0] r_inc;
    logic [XW-1:0] x_ext;
    logic [XW-1:0] lo_sq;
    logic [XW-1:0] hi_sq;

    // Two extra bits keep (r+1)^2 from wrapping at the all-ones root.
    always_comb begin
        r_ext    = XW'(sq_sqrt);
        r_inc    = r_ext + XW'(1);
        x_ext    = XW'(sq_xin);
        lo_sq    = r_ext * r_ext;
        hi_sq    = r_inc * r_inc;
        chk_fail = (lo_sq > x_ext) || (hi_sq <= x_ext);
    end
`else
    assign chk_fail = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            sq_start  <= 1'b0;
            sq_stop   <= 1'b0;
            sq_xin    <= '0;
            busy      <= 1'b0;
            check_err <= 1'b0;
        end else begin
            sq_start <= 1'b0;
            sq_stop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sq_xin   <= in_data;
                        sq_start <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt <= CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        sq_stop <= 1'b1;
                        state   <= STOP;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        sq_stop <= 1'b1;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_data  <= sq_sqrt;
                    check_err <= chk_fail;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        check_err <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Self-checking bench for psdsqrt_seq with a behavioural psdsqrt core model.
// A scoreboard queue holds expected results pushed at operand acceptance.
module tb_psdsqrt_seq;

    localparam int NB = 32;
    localparam int HB = NB / 2;
    localparam int L  = NB / 2;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [HB-1:0] out_data;
    logic          sq_start;
    logic          sq_stop;
    logic [NB-1:0] sq_xin;
    logic [HB-1:0] sq_sqrt;
    logic          busy;
    logic          check_err;

    int errors = 0;
    int checks = 0;
    logic [HB-1:0] bias = '0;

    logic [HB-1:0] exp_q[$];
    logic          chk_q[$];

    psdsqrt_seq #(
        .NUM_BITS(NB),
        .LATENCY (L)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sq_start (sq_start),
        .sq_stop  (sq_stop),
        .sq_xin   (sq_xin),
        .sq_sqrt  (sq_sqrt),
        .busy     (busy),
        .check_err(check_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Core model: integer square root of xin, optionally skewed by bias.
    function automatic logic [HB-1:0] isqrt(input logic [NB-1:0] x);
        logic [HB-1:0] r;
        logic [HB-1:0] t;
        longint unsigned sq;
        r = '0;
        for (int b = HB - 1; b >= 0; b--) begin
            t  = r | (HB'(1) << b);
            sq = longint'(t) * longint'(t);
            if (sq <= longint'(x)) r = t;
        end
        return r;
    endfunction

    always_comb sq_sqrt = isqrt(sq_xin) + bias;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One operation from acceptance to output handshake.
    task automatic run_op(input logic [NB-1:0] x, input logic [HB-1:0] expv,
                          input logic expchk, input int hold, input bit keep);
        logic [HB-1:0] e;
        logic          ec;
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready x=%0h got=%b want=1", x, in_ready);
        end
        exp_q.push_back(expv);
        chk_q.push_back(expchk);
        tick();
        if (!keep) in_valid = 1'b0;
        for (int k = 1; k <= L + 3; k++) begin
            checks++;
            if (sq_start !== (k == 1)) begin
                errors++;
                $display("FAIL sq_start x=%0h T+%0d got=%b want=%b", x, k, sq_start, k == 1);
            end
            checks++;
            if (sq_stop !== (k == L + 1)) begin
                errors++;
                $display("FAIL sq_stop x=%0h T+%0d got=%b want=%b", x, k, sq_stop, k == L + 1);
            end
            checks++;
            if (out_valid !== (k == L + 3)) begin
                errors++;
                $display("FAIL out_valid x=%0h T+%0d got=%b want=%b", x, k, out_valid, k == L + 3);
            end
            checks++;
            if (sq_xin !== x || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_op x=%0h T+%0d xin=%0h ready=%b busy=%b want xin=%0h 0 1",
                         x, k, sq_xin, in_ready, busy, x);
            end
            if (k < L + 3) tick();
        end
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== expv || in_ready !== 1'b0 || sq_start !== 1'b0) begin
                errors++;
                $display("FAIL stall x=%0h cyc=%0d valid=%b data=%0h ready=%b start=%b want 1 %0h 0 0",
                         x, h, out_valid, out_data, in_ready, sq_start, expv);
            end
            tick();
        end
        out_ready = 1'b1;
        e  = exp_q.pop_front();
        ec = chk_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            errors++;
            $display("FAIL result x=%0h valid=%b data=%0h want 1 %0h", x, out_valid, out_data, e);
        end
        checks++;
        if (check_err !== ec) begin
            errors++;
            $display("FAIL check_err x=%0h got=%b want=%b", x, check_err, ec);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sq_start !== 1'b0) begin
            errors++;
            $display("FAIL post_hs x=%0h valid=%b ready=%b busy=%b start=%b want 0 1 0 0",
                     x, out_valid, in_ready, busy, sq_start);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sq_start !== 1'b0 ||
            sq_stop !== 1'b0 || busy !== 1'b0 || sq_xin !== '0 ||
            out_data !== '0 || check_err !== 1'b0) begin
            errors++;
            $display("FAIL reset rdy=%b ov=%b st=%b sp=%b busy=%b xin=%0h od=%0h ce=%b",
                     in_ready, out_valid, sq_start, sq_stop, busy, sq_xin, out_data, check_err);
        end
    endtask

    task automatic test_basic();
        run_op(32'd144, 16'd12, 1'b0, 0, 1'b0);
    endtask

    task automatic test_boundary();
        run_op(32'd0, 16'd0, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 0, 1'b0);
        run_op(32'd1, 16'd1, 1'b0, 0, 1'b0);
        run_op(32'd1_000_000, 16'd1000, 1'b0, 1, 1'b0);
    endtask

    // in_valid stays high across a stalled output; next op follows one cycle later.
    task automatic test_back_to_back();
        run_op(32'd400, 16'd20, 1'b0, 5, 1'b1);
        run_op(32'd81, 16'd9, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1;
        in_data  = 32'd5000;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || sq_start !== 1'b0 ||
            sq_stop !== 1'b0 || out_valid !== 1'b0 || sq_xin !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b rdy=%b st=%b sp=%b ov=%b xin=%0h want 0 1 0 0 0 0",
                     busy, in_ready, sq_start, sq_stop, out_valid, sq_xin);
        end
        for (int k = 0; k < L + 5; k++) begin
            tick();
            checks++;
            if (sq_stop !== 1'b0 || out_valid !== 1'b0 || sq_start !== 1'b0) begin
                errors++;
                $display("FAIL aborted_op cyc=%0d stop=%b valid=%b start=%b want 0 0 0",
                         k, sq_stop, out_valid, sq_start);
            end
        end
        run_op(32'd81, 16'd9, 1'b0, 0, 1'b0);
    endtask

    task automatic test_check();
`ifdef PSDSQRT_SEQ_CHECK_EN
        bias = 16'd1;
        run_op(32'd144, 16'd13, 1'b1, 2, 1'b0);
        bias = 16'd0;
        run_op(32'd144, 16'd12, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 0, 1'b0);
`else
        bias = 16'd1;
        run_op(32'd144, 16'd13, 1'b0, 0, 1'b0);
        bias = 16'd0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        test_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
